// File: rtl/rcom_cmd_arbiter_if.sv
// Requester and RemoteComm signal bundle for the RemoteComm command arbiter.
// Requesters hold req until done/err; gnt is one-hot and spans the transaction.
// snd_cmd strobes cmd out once per attempt, and cmd_snt/resp_rdy are single-cycle replies.
interface rcom_cmd_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [16*NUM_REQ-1:0] req_cmd;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    done;
    logic [NUM_REQ-1:0]    err;
    logic [15:0]           cmd;
    logic                  snd_cmd;
    logic                  cmd_snt;
    logic [7:0]            resp;
    logic                  resp_rdy;
    logic [7:0]            last_resp;
    logic                  busy;
    logic [2:0]            dbg_state;

    modport master (
        output req, req_cmd, cmd_snt, resp, resp_rdy,
        input  gnt, done, err, cmd, snd_cmd, last_resp, busy, dbg_state
    );

    modport slave (
        input  req, req_cmd, cmd_snt, resp, resp_rdy,
        output gnt, done, err, cmd, snd_cmd, last_resp, busy, dbg_state
    );
endinterface

// File: rtl/rcom_cmd_arbiter.sv
// Round-robin arbiter sharing the RemoteComm command channel between NUM_REQ requesters,
// with per-attempt timeout, NAK retry and a done/err pulse per transaction.
module rcom_cmd_arbiter #(
    parameter int          NUM_REQ        = 4,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter int          RETRY_MAX      = 2,
    parameter logic [7:0]  ACK_VAL        = 8'hA5
) (
    input logic              clk,
    input logic              rst,
    rcom_cmd_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMR_MAX   = '1;
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_SNT  = 3'd2,
        S_WAIT_RESP = 3'd3,
        S_COOL      = 3'd4
    } state_e;

    state_e             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic [NUM_REQ-1:0] err_q;
    logic [15:0]        cmd_q;
    logic               snd_q;
    logic [7:0]         last_resp_q;
    logic [IW-1:0]      ptr_q;
    logic [IW-1:0]      gidx_q;
    logic [RW-1:0]      retry_q;
    logic [TW-1:0]      tmr_q;

    logic               sel_vld;
    logic [IW-1:0]      sel_idx;
    int                 sel_j;
    logic [IW-1:0]      ptr_d;
    logic               tmo;
    logic               attempt_fail;

    // First requesting index at or above the pointer, wrapping around.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        sel_j   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_j = int'(ptr_q) + k;
            if (sel_j >= NUM_REQ) sel_j = sel_j - NUM_REQ;
            if (!sel_vld && bus.req[sel_j]) begin
                sel_vld = 1'b1;
                sel_idx = IW'(sel_j);
            end
        end
    end

    assign ptr_d = (gidx_q == LAST_IDX) ? '0 : gidx_q + IW'(1);
    assign tmo   = (tmr_q == TMO_LAST);

    always_comb begin
        attempt_fail = 1'b0;
        case (state_q)
            S_WAIT_SNT:  attempt_fail = !bus.cmd_snt && tmo;
            S_WAIT_RESP: attempt_fail = bus.resp_rdy ? (bus.resp != ACK_VAL) : tmo;
            default:     attempt_fail = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            cmd_q       <= 16'h0000;
            snd_q       <= 1'b0;
            last_resp_q <= 8'h00;
            ptr_q       <= '0;
            gidx_q      <= '0;
            retry_q     <= '0;
            tmr_q       <= '0;
        end else begin
            snd_q  <= 1'b0;
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (sel_vld) begin
                        gidx_q  <= sel_idx;
                        gnt_q   <= NUM_REQ'(1) << sel_idx;
                        cmd_q   <= bus.req_cmd[{sel_idx, 4'b0000} +: 16];
                        retry_q <= '0;
                        snd_q   <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmr_q   <= '0;
                    state_q <= S_WAIT_SNT;
                end
                S_WAIT_SNT: begin
                    if (bus.cmd_snt) begin
                        tmr_q   <= '0;
                        state_q <= S_WAIT_RESP;
                    end else if (tmr_q != TMR_MAX) begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                S_WAIT_RESP: begin
                    if (bus.resp_rdy) begin
                        last_resp_q <= bus.resp;
                        if (bus.resp == ACK_VAL) begin
                            done_q  <= gnt_q;
                            gnt_q   <= '0;
                            ptr_q   <= ptr_d;
                            state_q <= S_COOL;
                        end
                    end else if (tmr_q != TMR_MAX) begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                S_COOL:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            // NAK or timeout: re-issue the latched cmd while retries remain, else give up.
            if (attempt_fail) begin
                if (retry_q < RETRY_LIM) begin
                    retry_q <= retry_q + RW'(1);
                    snd_q   <= 1'b1;
                    state_q <= S_ISSUE;
                end else begin
                    err_q   <= gnt_q;
                    gnt_q   <= '0;
                    ptr_q   <= ptr_d;
                    state_q <= S_COOL;
                end
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.cmd       = cmd_q;
    assign bus.snd_cmd   = snd_q;
    assign bus.last_resp = last_resp_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_rcom_cmd_arbiter.sv
// Directed bench for rcom_cmd_arbiter: grant order, NAK retry, timeout, boundary events
// and mid-transaction reset, each in its own task with hand-computed expectations.
module tb_rcom_cmd_arbiter;
    localparam int NR  = 4;
    localparam int TMO = 16;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   snd_cnt;
    int   done_cnt;
    int   err_cnt;
    int   cyc;

    rcom_cmd_arbiter_if #(.NUM_REQ(NR)) bus ();

    rcom_cmd_arbiter #(
        .NUM_REQ(NR),
        .TIMEOUT_CYCLES(TMO),
        .RETRY_MAX(2),
        .ACK_VAL(8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.snd_cmd) snd_cnt++;
        if (|bus.done) done_cnt++;
        if (|bus.err) err_cnt++;
    endtask

    task automatic set_cmd(input int i, input logic [15:0] v);
        bus.req_cmd[16*i +: 16] = v;
    endtask

    task automatic pulse_snt();
        bus.cmd_snt = 1'b1;
        tick();
        bus.cmd_snt = 1'b0;
    endtask

    task automatic pulse_resp(input logic [7:0] r);
        bus.resp     = r;
        bus.resp_rdy = 1'b1;
        tick();
        bus.resp_rdy = 1'b0;
    endtask

    task automatic wait_snd(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.snd_cmd) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic apply_reset();
        rst          = 1'b1;
        bus.req      = '0;
        bus.cmd_snt  = 1'b0;
        bus.resp_rdy = 1'b0;
        bus.resp     = 8'h00;
        tick();
        tick();
        rst      = 1'b0;
        snd_cnt  = 0;
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.req      = 4'b1111;
        bus.req_cmd  = '0;
        bus.cmd_snt  = 1'b0;
        bus.resp_rdy = 1'b0;
        bus.resp     = 8'h00;
        tick();
        tick();
        checks += 7;
        if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL rst_gnt: got %b want 0000", bus.gnt); end
        if (bus.done !== 4'b0000) begin failures++; $display("FAIL rst_done: got %b want 0000", bus.done); end
        if (bus.err !== 4'b0000) begin failures++; $display("FAIL rst_err: got %b want 0000", bus.err); end
        if (bus.cmd !== 16'h0000) begin failures++; $display("FAIL rst_cmd: got %h want 0000", bus.cmd); end
        if (bus.snd_cmd !== 1'b0) begin failures++; $display("FAIL rst_snd: got %b want 0", bus.snd_cmd); end
        if (bus.last_resp !== 8'h00) begin failures++; $display("FAIL rst_last_resp: got %h want 00", bus.last_resp); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        bus.req = '0;
        rst     = 1'b0;
        tick();
        tick();
        checks += 2;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_noreq_busy: got %b want 0", bus.busy); end
        if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL idle_noreq_gnt: got %b want 0000", bus.gnt); end
    endtask

    task automatic test_single();
        snd_cnt = 0;
        set_cmd(0, 16'h1111);
        set_cmd(1, 16'h2A57);
        set_cmd(2, 16'h3333);
        set_cmd(3, 16'h4444);
        bus.req = 4'b0010;
        tick();
        checks += 4;
        if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL single_gnt: got %b want 0010", bus.gnt); end
        if (bus.cmd !== 16'h2A57) begin failures++; $display("FAIL single_cmd: got %h want 2a57", bus.cmd); end
        if (bus.snd_cmd !== 1'b1) begin failures++; $display("FAIL single_snd: got %b want 1", bus.snd_cmd); end
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", bus.busy); end
        tick();
        checks++;
        if (bus.snd_cmd !== 1'b0) begin failures++; $display("FAIL single_snd_once: got %b want 0", bus.snd_cmd); end
        pulse_snt();
        pulse_resp(8'hA5);
        bus.req = '0;
        checks += 4;
        if (bus.done !== 4'b0010) begin failures++; $display("FAIL single_done: got %b want 0010", bus.done); end
        if (bus.last_resp !== 8'hA5) begin failures++; $display("FAIL single_last_resp: got %h want a5", bus.last_resp); end
        if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL single_gnt_drop: got %b want 0000", bus.gnt); end
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_cool_busy: got %b want 1", bus.busy); end
        tick();
        checks += 3;
        if (bus.done !== 4'b0000) begin failures++; $display("FAIL single_done_pulse: got %b want 0000", bus.done); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy: got %b want 0", bus.busy); end
        if (snd_cnt !== 1) begin failures++; $display("FAIL single_snd_count: got %0d want 1", snd_cnt); end
    endtask

    task automatic test_round_robin();
        bit          ok;
        logic [3:0]  exp_gnt;
        logic [15:0] exp_cmd;
        apply_reset();
        set_cmd(0, 16'hA000);
        set_cmd(1, 16'hA111);
        set_cmd(2, 16'hA222);
        set_cmd(3, 16'hA333);
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << (k % 4);
            exp_cmd = 16'hA000 + 16'h0111 * 16'(k % 4);
            bus.req = 4'b1111;
            wait_snd(ok);
            checks += 3;
            if (!ok) begin failures++; $display("FAIL rr_wait_snd[%0d]: no snd_cmd within bound", k); return; end
            if (bus.gnt !== exp_gnt) begin failures++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, bus.gnt, exp_gnt); end
            if (bus.cmd !== exp_cmd) begin failures++; $display("FAIL rr_cmd[%0d]: got %h want %h", k, bus.cmd, exp_cmd); end
            tick();
            pulse_snt();
            pulse_resp(8'hA5);
            checks++;
            if (bus.done !== exp_gnt) begin failures++; $display("FAIL rr_done[%0d]: got %b want %b", k, bus.done, exp_gnt); end
            bus.req = '0;
            tick();
        end
        checks++;
        if (snd_cnt !== 5) begin failures++; $display("FAIL rr_snd_count: got %0d want 5", snd_cnt); end
    endtask

    task automatic test_nak_retry();
        bit ok;
        apply_reset();
        set_cmd(0, 16'h1C3D);
        bus.req = 4'b0001;
        wait_snd(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL nak_wait_snd: no snd_cmd within bound"); return; end
        for (int a = 0; a < 3; a++) begin
            checks += 2;
            if (bus.snd_cmd !== 1'b1) begin failures++; $display("FAIL nak_reissue[%0d]: got %b want 1", a, bus.snd_cmd); end
            if (bus.cmd !== 16'h1C3D) begin failures++; $display("FAIL nak_cmd[%0d]: got %h want 1c3d", a, bus.cmd); end
            set_cmd(0, 16'hFFFF);
            tick();
            pulse_snt();
            pulse_resp((a < 2) ? 8'h5A : 8'hA5);
            if (a < 2) begin
                checks++;
                if (bus.last_resp !== 8'h5A) begin failures++; $display("FAIL nak_last_resp[%0d]: got %h want 5a", a, bus.last_resp); end
            end
        end
        bus.req = '0;
        checks += 3;
        if (bus.done !== 4'b0001) begin failures++; $display("FAIL nak_done: got %b want 0001", bus.done); end
        if (snd_cnt !== 3) begin failures++; $display("FAIL nak_snd_count: got %0d want 3", snd_cnt); end
        if (err_cnt !== 0) begin failures++; $display("FAIL nak_no_err: got %0d want 0", err_cnt); end
        tick();
    endtask

    task automatic test_nak_err();
        bit ok;
        snd_cnt  = 0;
        done_cnt = 0;
        err_cnt  = 0;
        set_cmd(0, 16'h0BAD);
        bus.req = 4'b0001;
        wait_snd(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL nakerr_wait_snd: no snd_cmd within bound"); return; end
        for (int a = 0; a < 3; a++) begin
            checks++;
            if (bus.cmd !== 16'h0BAD) begin failures++; $display("FAIL nakerr_cmd[%0d]: got %h want 0bad", a, bus.cmd); end
            tick();
            pulse_snt();
            pulse_resp(8'h5A);
        end
        bus.req = '0;
        checks += 5;
        if (bus.err !== 4'b0001) begin failures++; $display("FAIL nakerr_err: got %b want 0001", bus.err); end
        if (bus.done !== 4'b0000) begin failures++; $display("FAIL nakerr_done: got %b want 0000", bus.done); end
        if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL nakerr_gnt: got %b want 0000", bus.gnt); end
        if (snd_cnt !== 3) begin failures++; $display("FAIL nakerr_snd_count: got %0d want 3", snd_cnt); end
        if (done_cnt !== 0) begin failures++; $display("FAIL nakerr_done_count: got %0d want 0", done_cnt); end
        tick();
        checks += 2;
        if (bus.err !== 4'b0000) begin failures++; $display("FAIL nakerr_err_pulse: got %b want 0000", bus.err); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL nakerr_idle: got %b want 0", bus.busy); end
    endtask

    task automatic test_timeout();
        bit ok;
        int first_snd;
        int last_snd;
        snd_cnt = 0;
        err_cnt = 0;
        set_cmd(1, 16'h7E01);
        bus.req = 4'b0010;
        wait_snd(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL tmo_wait_snd: no snd_cmd within bound"); return; end
        first_snd = cyc;
        last_snd  = cyc;
        for (int n = 0; n < 3 * (TMO + 1) + 10; n++) begin
            tick();
            if (bus.snd_cmd) last_snd = cyc;
            if (|bus.err) break;
        end
        bus.req = '0;
        checks += 4;
        if (bus.err !== 4'b0010) begin failures++; $display("FAIL tmo_err: got %b want 0010", bus.err); end
        if (snd_cnt !== 3) begin failures++; $display("FAIL tmo_snd_count: got %0d want 3", snd_cnt); end
        if (last_snd - first_snd !== 2 * (TMO + 1)) begin
            failures++;
            $display("FAIL tmo_period: got %0d want %0d", last_snd - first_snd, 2 * (TMO + 1));
        end
        if (cyc - last_snd !== TMO + 1) begin failures++; $display("FAIL tmo_err_delay: got %0d want %0d", cyc - last_snd, TMO + 1); end
        tick();
        checks += 2;
        if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL tmo_gnt_after: got %b want 0000", bus.gnt); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL tmo_idle: got %b want 0", bus.busy); end
    endtask

    task automatic test_boundary();
        bit ok;
        apply_reset();
        set_cmd(2, 16'h4C21);
        bus.req = 4'b0100;
        wait_snd(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bnd_wait_snd: no snd_cmd within bound"); return; end
        tick();
        bus.cmd_snt  = 1'b1;
        bus.resp     = 8'h5A;
        bus.resp_rdy = 1'b1;
        tick();
        bus.cmd_snt  = 1'b0;
        bus.resp_rdy = 1'b0;
        checks += 3;
        if (bus.last_resp !== 8'h00) begin failures++; $display("FAIL bnd_coincident_resp: got %h want 00", bus.last_resp); end
        if (snd_cnt !== 1) begin failures++; $display("FAIL bnd_no_retry: got %0d want 1", snd_cnt); end
        if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL bnd_gnt: got %b want 0100", bus.gnt); end
        bus.req = '0;
        tick();
        tick();
        checks += 2;
        if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL bnd_req_drop_gnt: got %b want 0100", bus.gnt); end
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL bnd_req_drop_busy: got %b want 1", bus.busy); end
        pulse_resp(8'hA5);
        checks += 3;
        if (bus.done !== 4'b0100) begin failures++; $display("FAIL bnd_done: got %b want 0100", bus.done); end
        if (bus.last_resp !== 8'hA5) begin failures++; $display("FAIL bnd_last_resp: got %h want a5", bus.last_resp); end
        if (snd_cnt !== 1) begin failures++; $display("FAIL bnd_snd_count: got %0d want 1", snd_cnt); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        bus.req = 4'b0100;
        wait_snd(ok);
        checks += 2;
        if (!ok) begin failures++; $display("FAIL rmid_wait_snd: no snd_cmd within bound"); return; end
        if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL rmid_gnt: got %b want 0100", bus.gnt); end
        tick();
        pulse_snt();
        done_cnt = 0;
        err_cnt  = 0;
        rst      = 1'b1;
        tick();
        checks += 7;
        if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL rmid_gnt_clr: got %b want 0000", bus.gnt); end
        if (bus.done !== 4'b0000) begin failures++; $display("FAIL rmid_done: got %b want 0000", bus.done); end
        if (bus.err !== 4'b0000) begin failures++; $display("FAIL rmid_err: got %b want 0000", bus.err); end
        if (bus.cmd !== 16'h0000) begin failures++; $display("FAIL rmid_cmd: got %h want 0000", bus.cmd); end
        if (bus.snd_cmd !== 1'b0) begin failures++; $display("FAIL rmid_snd: got %b want 0", bus.snd_cmd); end
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
        if (bus.last_resp !== 8'h00) begin failures++; $display("FAIL rmid_last_resp: got %h want 00", bus.last_resp); end
        rst     = 1'b0;
        bus.req = 4'b1100;
        tick();
        checks += 3;
        if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL rmid_regrant: got %b want 0100", bus.gnt); end
        if (done_cnt !== 0) begin failures++; $display("FAIL rmid_done_count: got %0d want 0", done_cnt); end
        if (err_cnt !== 0) begin failures++; $display("FAIL rmid_err_count: got %0d want 0", err_cnt); end
        bus.req = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        snd_cnt  = 0;
        done_cnt = 0;
        err_cnt  = 0;
        cyc      = 0;
        rst      = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_nak_retry();
        test_nak_err();
        test_timeout();
        test_boundary();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rcom_cmd_arbiter.md
Name: rcom_cmd_arbiter

Overview:
- Shares the single RemoteComm command channel (16-bit cmd, snd_cmd pulse, cmd_snt pulse, 8-bit response) between NUM_REQ on-chip requesters.
- Grants round-robin, issues the winner's command and waits for the 8'hA5 positive acknowledge.
- Retries on NAK or timeout, and reports done or err per requester.
- Sits between the test/sequencing logic and RemoteComm in the JumpKnight command path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 4096, cycles allowed in each wait state before a timeout fires.
- RETRY_MAX, 2, re-issues permitted after the first attempt before err.
- ACK_VAL, 8'hA5, response value treated as positive acknowledge.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; must be held until that requester's done or err.
- req_cmd  in  16*NUM_REQ  per-requester command; slice i is [16*i+15:16*i].
- gnt  out  NUM_REQ  one-hot grant, high for the whole transaction.
- done  out  NUM_REQ  one-cycle pulse: ACK_VAL received.
- err  out  NUM_REQ  one-cycle pulse: retries exhausted.
- cmd  out  16  command to RemoteComm, registered, stable from issue until the next issue.
- snd_cmd  out  1  one-cycle issue strobe.
- cmd_snt  in  1  RemoteComm pulse: command fully transmitted.
- resp  in  8  response byte, valid with resp_rdy.
- resp_rdy  in  1  response valid pulse.
- last_resp  out  8  last response byte captured in WAIT_RESP.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs are 0, cmd=16'h0000, last_resp=8'h00, state=IDLE, round-robin pointer=0, retry count=0, timer=0.
- States: IDLE, ISSUE, WAIT_SNT, WAIT_RESP, COOL.
- IDLE, when req is nonzero:
  - Select the first set bit searching upward, with wrap, starting from the pointer.
  - At that edge: gnt[i]=1, cmd=req_cmd slice i, retry count=0, go to ISSUE.
  - Request deasserted while in IDLE: no grant.
- ISSUE:
  - snd_cmd=1 for exactly this one cycle. The first snd_cmd is therefore the cycle after the IDLE edge that registers gnt.
  - Timer cleared. Next state WAIT_SNT.
- WAIT_SNT:
  - cmd_snt=1: go to WAIT_RESP, timer cleared.
  - resp_rdy is ignored in this state, including when it coincides with cmd_snt.
  - Timer reaching TIMEOUT_CYCLES-1 without cmd_snt counts as a failed attempt.
- WAIT_RESP, on resp_rdy: last_resp=resp, then:
  - resp==ACK_VAL: done[i]=1, gnt=0, pointer=i+1 mod NUM_REQ, go to COOL.
  - Any other resp: failed attempt.
  - Timeout in WAIT_RESP is also a failed attempt.
- Failed attempt:
  - Retry count < RETRY_MAX: increment it and go to ISSUE. cmd is unchanged and gnt is held.
  - Otherwise: err[i]=1, gnt=0, pointer=i+1, go to COOL.
- COOL: one cycle with no arbitration, then IDLE. The requester must drop req in the cycle after done/err, so the earliest next grant edge is 2 cycles after the done/err cycle.
- Requester deasserting req mid-transaction: ignored; the transaction runs to done/err.
- Changes to req_cmd after grant: not seen, because cmd is latched.
- cmd_snt or resp_rdy in IDLE, ISSUE or COOL: ignored.
- Timer width is clog2(TIMEOUT_CYCLES). The timer saturates and never wraps.
- rst asserted mid-transaction: full return to reset values at that edge, no done/err pulse, pointer returns to 0.
- Invariants:
  - At most one gnt bit high.
  - done and err are never both high.
  - snd_cmd is high only in ISSUE.

Test Plan:
- Single request: req=4'b0010, slice1=16'h2A57 → gnt=0010 and cmd=16'h2A57 next cycle, then one snd_cmd pulse. Drive cmd_snt, then resp_rdy with resp=8'hA5 → done=0010 for 1 cycle, last_resp=8'hA5, busy low 2 cycles later.
- Round-robin: req=4'b1111 held and re-raised after each done, every reply 8'hA5 → grant order 0,1,2,3,0; exactly one snd_cmd per grant.
- NAK retry: resp=8'h5A twice, then 8'hA5 → exactly 3 snd_cmd pulses with the same cmd, then done. Repeat with three NAKs → 3 snd_cmd pulses, then err pulse, done never asserted.
- Timeout: cmd_snt never asserted → snd_cmd re-issued every TIMEOUT_CYCLES+1 cycles, err after 3 total issues, gnt low afterwards.
- Boundary events:
  - resp_rdy coincident with cmd_snt in WAIT_SNT → response ignored; the second resp_rdy=8'hA5 gives done.
  - req[i] dropped mid-WAIT_RESP → transaction still completes with done.
- Reset mid-op: assert rst during WAIT_RESP with gnt=0100 → next cycle all outputs 0, no done/err. After rst low, req=4'b1100 → requester 2 granted first (pointer=0 search).
